pipeline_step_ctrl: RTL

- Debug execution controller for the MIPS pipeline.
- Generates the shared step-enable that every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) samples.
- Sequences continuous run, single-step and run-N-cycles modes from debug-unit commands.
- Detects a fetched HALT, drains the pipeline for a fixed number of steps, then freezes it.

---
 rtl/pipeline_step_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_step_ctrl.sv
// Debug execution controller for the MIPS pipeline.
// Produces the single step-enable that all inter-stage registers, the PC and
// the register-file write port sample. Supports continuous run, single step
// and run-N modes, and drains/freezes the pipeline after a fetched HALT.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | pipeline frozen, waiting for a debug command
// ST_RUN    | stepping every cycle until STOP or HALT
// ST_STEP   | one step cycle, then back to IDLE
// ST_RUN_N  | stepping while remaining count is non-zero
// ST_DRAIN  | HALT seen in IF/ID, pushing it through ID, EX, MEM, WB
// ST_HALTED | HALT retired, frozen until reset
module pipeline_step_ctrl #(
    parameter int NB_COUNT    = 32,
    parameter int DRAIN_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    input  logic [1:0]          i_cmd,
    input  logic [NB_COUNT-1:0] i_cmd_count,
    output logic                o_cmd_ready,
    input  logic                i_halt_fetched,
    output logic                o_step,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_halted,
    output logic [NB_COUNT-1:0] o_step_count,
    output logic [2:0]          o_state
);

    localparam int NB_DRAIN = (DRAIN_DEPTH < 2) ? 1 : $clog2(DRAIN_DEPTH + 1);

    localparam logic [1:0] CMD_STOP  = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_RUN_N = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_RUN_N  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    state_t                state_q,  state_d;
    logic [NB_COUNT-1:0]   remain_q, remain_d;
    logic [NB_DRAIN-1:0]   drain_q,  drain_d;
    logic [NB_COUNT-1:0]   cnt_q,    cnt_d;
    logic                  step_q,   step_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  halted_q, halted_d;
    logic                  ready_q,  ready_d;
    logic                  cmd_acc;
    logic                  stop_acc;

    assign cmd_acc  = i_cmd_valid && ready_q;
    assign stop_acc = cmd_acc && (i_cmd == CMD_STOP);

    // Next-state, counters and done pulse; HALT is checked first in every
    // stepping state so it wins over completion and a simultaneous STOP.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        drain_d  = drain_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (i_cmd)
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        CMD_RUN_N: begin
                            if (i_cmd_count == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d  = ST_RUN_N;
                                remain_d = i_cmd_count;
                            end
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end

            ST_RUN: begin
                if (i_halt_fetched) begin
                    if (DRAIN_DEPTH == 0) begin
                        state_d = ST_HALTED;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = NB_DRAIN'(DRAIN_DEPTH);
                    end
                end else if (stop_acc) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            ST_STEP: begin
                if (i_halt_fetched) begin
                    if (DRAIN_DEPTH == 0) begin
                        state_d = ST_HALTED;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = NB_DRAIN'(DRAIN_DEPTH);
                    end
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            ST_RUN_N: begin
                if (i_halt_fetched) begin
                    remain_d = '0;
                    if (DRAIN_DEPTH == 0) begin
                        state_d = ST_HALTED;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = NB_DRAIN'(DRAIN_DEPTH);
                    end
                end else if (stop_acc || (remain_q == NB_COUNT'(1))) begin
                    state_d  = ST_IDLE;
                    remain_d = '0;
                    done_d   = 1'b1;
                end else begin
                    remain_d = remain_q - NB_COUNT'(1);
                end
            end

            ST_DRAIN: begin
                if (drain_q <= NB_DRAIN'(1)) begin
                    state_d = ST_HALTED;
                    drain_d = '0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - NB_DRAIN'(1);
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d  = ST_IDLE;
                remain_d = '0;
                drain_d  = '0;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        step_d   = (state_d == ST_RUN) || (state_d == ST_STEP) ||
                   (state_d == ST_RUN_N) || (state_d == ST_DRAIN);
        busy_d   = step_d;
        halted_d = (state_d == ST_HALTED);
        ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN) ||
                   (state_d == ST_RUN_N);
        cnt_d    = cnt_q;
        if (step_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + NB_COUNT'(1);
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            drain_q  <= '0;
            cnt_q    <= '0;
            step_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            drain_q  <= drain_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            halted_q <= halted_d;
            ready_q  <= ready_d;
        end
    end

    assign o_cmd_ready  = ready_q;
    assign o_step       = step_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_halted     = halted_q;
    assign o_step_count = cnt_q;
    assign o_state      = state_q;

endmodule
